// File: rtl/pipe_ctrl.sv
// Pipeline sequencer for the 5-stage core: per-stage enables/flushes and PC redirect,
// with a drain state that parks a mispredict until an uncancellable fetch returns.
module pipe_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_use_hazard,
  input  logic            ex_mispredict,
  input  logic [XLEN-1:0] ex_target,
  input  logic            if_valid,
  input  logic            mem_req,
  input  logic            mem_done,
  output logic            pc_en,
  output logic            pc_redirect,
  output logic [XLEN-1:0] pc_redirect_addr,
  output logic            if_id_en,
  output logic            if_id_flush,
  output logic            id_ex_en,
  output logic            id_ex_flush,
  output logic            ex_mem_en,
  output logic            mem_wb_en,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  typedef enum logic {RUN, DRAIN} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t          state, state_nx;
  logic [XLEN-1:0] tgt_q;
  logic            tgt_ld, flush_acc, mem_wait;
  logic [2:0]      back;

  assign mem_wait = mem_req & ~mem_done;
  assign {id_ex_en, ex_mem_en, mem_wb_en} = back;

  always_comb begin
    state_nx         = state;
    tgt_ld           = 1'b0;
    flush_acc        = 1'b0;
    pc_en            = 1'b0;
    pc_redirect      = 1'b0;
    pc_redirect_addr = '0;
    if_id_en         = 1'b0;
    if_id_flush      = 1'b0;
    id_ex_flush      = 1'b0;
    back             = 3'b000;
    // Reset gates every control low, including the same-cycle redirect path.
    if (rst_n && !mem_wait) begin
      unique case (state)
        RUN: begin
          if (ex_mispredict) begin
            back        = 3'b111;
            id_ex_flush = 1'b1;
            if_id_en    = 1'b1;
            if_id_flush = 1'b1;
            flush_acc   = 1'b1;
            if (if_valid) begin
              pc_en            = 1'b1;
              pc_redirect      = 1'b1;
              pc_redirect_addr = ex_target;
            end else begin
              tgt_ld   = 1'b1;
              state_nx = DRAIN;
            end
          end else if (load_use_hazard) begin
            back        = 3'b111;
            id_ex_flush = 1'b1;
          end else if (!if_valid) begin
            back        = 3'b111;
            if_id_en    = 1'b1;
            if_id_flush = 1'b1;
          end else begin
            back     = 3'b111;
            if_id_en = 1'b1;
            pc_en    = 1'b1;
          end
        end
        DRAIN: begin
          // Keep bubbling ID/EX; the wrong-path word is dropped when it lands.
          back        = 3'b111;
          id_ex_flush = 1'b1;
          if_id_en    = 1'b1;
          if_id_flush = 1'b1;
          if (if_valid) begin
            pc_en            = 1'b1;
            pc_redirect      = 1'b1;
            pc_redirect_addr = tgt_q;
            state_nx         = RUN;
          end
        end
        default: state_nx = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      tgt_q     <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state <= state_nx;
      if (tgt_ld) tgt_q <= ex_target;
      if (!pc_en && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_ONE;
      if (flush_acc && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_ONE;
    end
  end
endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomized bench for pipe_ctrl against a rule-level reference model with a
// pending-redirect slot; directed preamble covers reset, hazards, drain and saturation.
module tb_pipe_ctrl;
  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  logic            clk = 1'b0;
  logic            rst_n, load_use_hazard, ex_mispredict, if_valid, mem_req, mem_done;
  logic [XLEN-1:0] ex_target;
  logic            pc_en, pc_redirect, if_id_en, if_id_flush;
  logic            id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en;
  logic [XLEN-1:0] pc_redirect_addr;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int errs = 0, checks = 0;

  // reference model state
  bit              m_pend;
  logic [XLEN-1:0] m_tgt;
  int              m_stall, m_flush;
  localparam int CMAX = (1 << CNT_W) - 1;

  pipe_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .load_use_hazard(load_use_hazard),
    .ex_mispredict(ex_mispredict), .ex_target(ex_target), .if_valid(if_valid),
    .mem_req(mem_req), .mem_done(mem_done), .pc_en(pc_en), .pc_redirect(pc_redirect),
    .pc_redirect_addr(pc_redirect_addr), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
    .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush), .ex_mem_en(ex_mem_en),
    .mem_wb_en(mem_wb_en), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One cycle: check registered counters, drive inputs, check combinational controls,
  // then advance the model to what the next clock edge should commit.
  task automatic step(input bit r, input bit lu, input bit mp, input logic [XLEN-1:0] tg,
                      input bit iv, input bit mrq, input bit mdn);
    logic [7:0]      ectl;
    logic [XLEN-1:0] eaddr;
    bit              mw;
    @(negedge clk);
    chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
    chk("flush_cnt", 64'(flush_cnt), 64'(m_flush));
    rst_n = r; load_use_hazard = lu; ex_mispredict = mp; ex_target = tg;
    if_valid = iv; mem_req = mrq; mem_done = mdn;
    #1;
    // ctl = {pc_en, redirect, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en}
    ectl = 8'h00; eaddr = '0;
    mw = mrq && !mdn;
    if (!r) begin
      m_pend = 0; m_tgt = '0; m_stall = 0; m_flush = 0;
    end else begin
      if (mw) ectl = 8'h00;
      else if (m_pend) begin
        ectl = 8'b0011_1111;
        if (iv) begin ectl[7:6] = 2'b11; eaddr = m_tgt; m_pend = 0; end
      end else if (mp) begin
        ectl = 8'b0011_1111;
        if (m_flush < CMAX) m_flush++;
        if (iv) begin ectl[7:6] = 2'b11; eaddr = tg; end
        else begin m_pend = 1; m_tgt = tg; end
      end else if (lu) ectl = 8'b0000_1111;
      else if (!iv)    ectl = 8'b0011_1011;
      else             ectl = 8'b1010_1011;
      if (!ectl[7] && m_stall < CMAX) m_stall++;
    end
    chk("ctl", 64'({pc_en, pc_redirect, if_id_en, if_id_flush,
                     id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en}), 64'(ectl));
    chk("redirect_addr", 64'(pc_redirect_addr), 64'(eaddr));
  endtask

  initial begin
    rst_n = 0; load_use_hazard = 0; ex_mispredict = 1; ex_target = 32'h44;
    if_valid = 1; mem_req = 0; mem_done = 0;
    m_pend = 0; m_tgt = '0; m_stall = 0; m_flush = 0;
    // 1: reset held with mispredict + if_valid asserted
    repeat (3) step(0, 0, 1, 32'h44, 1, 0, 0);
    step(1, 0, 0, 0, 1, 0, 0);
    chk("quiet_run_all_en", 64'({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}), 64'h1f);
    // 2: load-use
    step(1, 1, 0, 0, 1, 0, 0);
    chk("lu_pc_en", 64'(pc_en), 64'd0);
    step(1, 0, 0, 0, 1, 0, 0);
    chk("lu_stall_cnt", 64'(stall_cnt), 64'd1);
    // 3: same-cycle redirect
    step(1, 0, 1, 32'h100, 1, 0, 0);
    chk("mp_addr", 64'(pc_redirect_addr), 64'h100);
    step(1, 0, 0, 0, 1, 0, 0);
    chk("mp_flush_cnt", 64'(flush_cnt), 64'd1);
    // 4: mispredict with fetch outstanding, target parked, ex_target noise ignored
    step(1, 0, 1, 32'h200, 0, 0, 0);
    repeat (3) step(1, 1, 1, 32'hDEAD, 0, 0, 0);
    step(1, 0, 0, 32'hDEAD, 1, 0, 0);
    chk("drain_addr", 64'(pc_redirect_addr), 64'h200);
    step(1, 0, 0, 0, 1, 0, 0);
    // 5: mem wait freezes mispredict, then applies on mem_done
    repeat (4) step(1, 0, 1, 32'h300, 1, 1, 0);
    step(1, 0, 1, 32'h300, 1, 1, 1);
    chk("mw_release_redir", 64'(pc_redirect), 64'd1);
    // 6: drain with if_valid during mem_wait, then mem_done
    step(1, 0, 1, 32'h400, 0, 0, 0);
    repeat (2) step(1, 0, 0, 0, 1, 1, 0);
    step(1, 0, 0, 0, 1, 1, 1);
    chk("drain_mw_addr", 64'(pc_redirect_addr), 64'h400);
    // saturation: 20 stall cycles
    repeat (20) step(1, 1, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 1, 0, 0);
    chk("stall_sat", 64'(stall_cnt), 64'd15);
    // reset mid-drain loses the pending target
    step(1, 0, 1, 32'h500, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 0, 0);
    chk("rst_drain_noredir", 64'(pc_redirect), 64'd0);
    // random
    for (int i = 0; i < 3000; i++) begin
      bit mrq, r;
      r   = ($urandom_range(0, 199) != 0);
      mrq = ($urandom_range(0, 3) == 0);
      step(r, $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0, $urandom,
           $urandom_range(0, 2) != 0, mrq, $urandom_range(0, 1) == 1);
    end
    step(1, 0, 0, 0, 1, 0, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
